// File: rtl/io_debounce_if.sv
// Board-input bundle: raw DIP/button levels and acknowledge in, conditioned levels and press flags out.
// Pure wiring, no latency of its own.
// No flow control; the consumer samples levels whenever it likes and acknowledges flags with btn_clr.
interface io_debounce_if;
    logic [7:0] sw1_raw;
    logic [7:0] sw2_raw;
    logic [7:0] btn1_raw;
    logic       btn_clr;
    logic [7:0] sw1;
    logic [7:0] sw2;
    logic [7:0] btn1;
    logic [7:0] btn1_level;

    // Board/CPU side: drives the raw pins and the acknowledge, reads conditioned values.
    modport master (
        output sw1_raw,
        output sw2_raw,
        output btn1_raw,
        output btn_clr,
        input  sw1,
        input  sw2,
        input  btn1,
        input  btn1_level
    );

    // Conditioning block side.
    modport slave (
        input  sw1_raw,
        input  sw2_raw,
        input  btn1_raw,
        input  btn_clr,
        output sw1,
        output sw2,
        output btn1,
        output btn1_level
    );
endinterface

// File: rtl/io_debounce.sv
// Synchronises and debounces 24 raw board inputs; sticky press flags for the 8 buttons.
// Latency: SYNC_STAGES + DB_COUNT edges from a clean raw change to the output level.
// No backpressure; flags hold until btn_clr, and a rise on the same edge as btn_clr wins.
module io_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_WIDTH    = 16,
    parameter int DB_COUNT    = 50000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic          mem_clk,
    input  logic          mem_reset,
    io_debounce_if.slave  bus
);

    // Channel layout: [7:0] DIP bank 1, [15:8] DIP bank 2, [23:16] push buttons.
    localparam int NCH      = 24;
    localparam int BTN_BASE = 16;

    // Configuration sanity: the chain needs two flops for metastability settling, and
    // the terminal count must be representable so the counter can never wrap.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("io_debounce: SYNC_STAGES must be at least 2");
    end
    if ((DB_COUNT < 1) || (64'(DB_COUNT) > ((64'd1 << DB_WIDTH) - 64'd1))) begin : g_bad_count
        $error("io_debounce: DB_COUNT must be in 1 .. 2**DB_WIDTH-1");
    end

    localparam logic [DB_WIDTH-1:0] CNT_LAST = DB_WIDTH'(DB_COUNT - 1);
    localparam logic [DB_WIDTH-1:0] CNT_ONE  = DB_WIDTH'(1);

    // ------------------------------------------------------------------
    // Polarity normalisation: after this point a 1 always means on/pressed.
    // ------------------------------------------------------------------
    logic [NCH-1:0] raw_all;
    logic [NCH-1:0] x_in;

    assign raw_all = {bus.btn1_raw, bus.sw2_raw, bus.sw1_raw};
    assign x_in    = (ACTIVE_LOW != 0) ? ~raw_all : raw_all;

    // ------------------------------------------------------------------
    // Synchroniser chain, one flop per stage per bit.
    // ------------------------------------------------------------------
    logic [NCH-1:0] sync_q [SYNC_STAGES];
    logic [NCH-1:0] s;

    assign s = sync_q[SYNC_STAGES-1];

    // Shift the normalised inputs through the synchroniser stages.
    always_ff @(posedge mem_clk or posedge mem_reset) begin
        if (mem_reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= x_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Debounce: each channel counts consecutive cycles of disagreement
    // between the synchronised input and its accepted level. Any cycle of
    // agreement zeroes the count, so a bounce restarts the qualification.
    // ------------------------------------------------------------------
    logic [DB_WIDTH-1:0] cnt_q [NCH];
    logic [DB_WIDTH-1:0] cnt_d [NCH];
    logic [NCH-1:0]      stable_q;
    logic [NCH-1:0]      stable_d;

    // Next-state for every channel's accepted level and run-length counter.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = '0;
            if (s[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Register accepted levels and counters; reset discards any partial count.
    always_ff @(posedge mem_clk or posedge mem_reset) begin
        if (mem_reset) begin
            stable_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky press flags. The rise is taken from the level being accepted
    // on this edge, so the flag and btn1_level go high together. Set is
    // OR'd in after the clear term so a coincident press is never lost.
    // ------------------------------------------------------------------
    logic [7:0] btn_now;
    logic [7:0] btn_next;
    logic [7:0] rise;
    logic [7:0] flag_q;
    logic [7:0] flag_d;

    assign btn_now  = stable_q[BTN_BASE +: 8];
    assign btn_next = stable_d[BTN_BASE +: 8];
    assign rise     = btn_next & ~btn_now;
    assign flag_d   = rise | (flag_q & ~{8{bus.btn_clr}});

    // Hold each flag until software's acknowledging read.
    always_ff @(posedge mem_clk or posedge mem_reset) begin
        if (mem_reset) begin
            flag_q <= '0;
        end else begin
            flag_q <= flag_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs come straight from registers; nothing combinational from raw pins.
    // ------------------------------------------------------------------
    assign bus.sw1        = stable_q[7:0];
    assign bus.sw2        = stable_q[15:8];
    assign bus.btn1_level = stable_q[23:16];
    assign bus.btn1       = flag_q;

endmodule

// File: tb/tb_io_debounce.sv
// Directed bench for io_debounce: one instance with active-low inputs and DB_COUNT=4,
// a second with active-high inputs and DB_COUNT=1, sharing clock and reset.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
module tb_io_debounce;

    logic mem_clk;
    logic mem_reset;

    io_debounce_if bus0 ();
    io_debounce_if bus1 ();

    io_debounce #(
        .SYNC_STAGES (2),
        .DB_WIDTH    (16),
        .DB_COUNT    (4),
        .ACTIVE_LOW  (1)
    ) u_dut_al (
        .mem_clk   (mem_clk),
        .mem_reset (mem_reset),
        .bus       (bus0)
    );

    io_debounce #(
        .SYNC_STAGES (2),
        .DB_WIDTH    (16),
        .DB_COUNT    (1),
        .ACTIVE_LOW  (0)
    ) u_dut_ah (
        .mem_clk   (mem_clk),
        .mem_reset (mem_reset),
        .bus       (bus1)
    );

    int tests  = 0;
    int failed = 0;

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with every DIP in bank 1 switched on (active low => raw 0).
        mem_reset     = 1'b1;
        bus0.sw1_raw  = 8'h00;
        bus0.sw2_raw  = 8'hFF;
        bus0.btn1_raw = 8'hFF;
        bus0.btn_clr  = 1'b0;
        bus1.sw1_raw  = 8'h00;
        bus1.sw2_raw  = 8'h00;
        bus1.btn1_raw = 8'h00;
        bus1.btn_clr  = 1'b0;

        ticks(3);
        chk("rst_sw1",   bus0.sw1,        8'h00);
        chk("rst_sw2",   bus0.sw2,        8'h00);
        chk("rst_btn1",  bus0.btn1,       8'h00);
        chk("rst_level", bus0.btn1_level, 8'h00);
        chk("rst_ah_sw1", bus1.sw1,       8'h00);

        // Release: bank 1 must appear after exactly 6 edges.
        mem_reset = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            tick();
            chk($sformatf("rel_sw1_e%0d", n), bus0.sw1, 8'h00);
        end
        tick();
        chk("rel_sw1_e6", bus0.sw1, 8'hFF);
        chk("rel_sw2_e6", bus0.sw2, 8'h00);

        // Glitch: bank 2 bit 0 low for 3 cycles never reaches the output.
        bus0.sw2_raw = 8'hFE;
        ticks(3);
        bus0.sw2_raw = 8'hFF;
        for (int n = 4; n <= 9; n++) begin
            tick();
            chk($sformatf("glitch3_e%0d", n), bus0.sw2, 8'h00);
        end

        // Four cycles low is just enough.
        bus0.sw2_raw = 8'hFE;
        ticks(4);
        bus0.sw2_raw = 8'hFF;
        tick();
        chk("glitch4_e5", bus0.sw2, 8'h00);
        tick();
        chk("glitch4_e6", bus0.sw2, 8'h01);
        ticks(8);
        chk("glitch4_settle", bus0.sw2, 8'h00);

        // Bounce on button 2: single-cycle toggles, then held pressed.
        for (int i = 0; i < 10; i++) begin
            bus0.btn1_raw = (i % 2 == 0) ? 8'hFB : 8'hFF;
            tick();
        end
        chk("bounce_level_mid", bus0.btn1_level, 8'h00);
        bus0.btn1_raw = 8'hFB;
        ticks(5);
        chk("bounce_level_e5", bus0.btn1_level, 8'h00);
        chk("bounce_flag_e5",  bus0.btn1,       8'h00);
        tick();
        chk("bounce_level_e6", bus0.btn1_level, 8'h04);
        chk("bounce_flag_e6",  bus0.btn1,       8'h04);

        // Held button: acknowledge while held, flag must not re-arm.
        bus0.btn_clr = 1'b1;
        tick();
        bus0.btn_clr = 1'b0;
        chk("held_clr", bus0.btn1, 8'h00);
        ticks(6);
        chk("held_noreset", bus0.btn1, 8'h00);
        chk("held_level",   bus0.btn1_level, 8'h04);
        bus0.btn1_raw = 8'hFF;
        ticks(8);
        chk("rel2_flag",  bus0.btn1,       8'h00);
        chk("rel2_level", bus0.btn1_level, 8'h00);

        // Sticky flag on button 5 survives release until acknowledged.
        bus0.btn1_raw = 8'hDF;
        ticks(8);
        chk("b5_press_flag", bus0.btn1, 8'h20);
        bus0.btn1_raw = 8'hFF;
        ticks(8);
        chk("b5_rel_flag",  bus0.btn1,       8'h20);
        chk("b5_rel_level", bus0.btn1_level, 8'h00);
        bus0.btn_clr = 1'b1;
        tick();
        bus0.btn_clr = 1'b0;
        chk("b5_ack", bus0.btn1, 8'h00);

        // Set wins: flag 0 pending, acknowledge on the edge button 3 is accepted.
        bus0.btn1_raw = 8'hFE;
        ticks(8);
        bus0.btn1_raw = 8'hFF;
        ticks(8);
        chk("sw_flag0", bus0.btn1, 8'h01);
        bus0.btn1_raw = 8'hF7;
        ticks(5);
        chk("sw_pre", bus0.btn1, 8'h01);
        bus0.btn_clr = 1'b1;
        tick();
        bus0.btn_clr = 1'b0;
        chk("sw_flag",  bus0.btn1,       8'h08);
        chk("sw_level", bus0.btn1_level, 8'h08);
        ticks(3);
        chk("sw_hold", bus0.btn1, 8'h08);

        // Active-high, DB_COUNT=1 instance: both banks land together after 3 edges.
        bus1.sw1_raw = 8'hA5;
        bus1.sw2_raw = 8'h3C;
        ticks(2);
        chk("pol_sw1_e2", bus1.sw1, 8'h00);
        chk("pol_sw2_e2", bus1.sw2, 8'h00);
        tick();
        chk("pol_sw1_e3",   bus1.sw1,        8'hA5);
        chk("pol_sw2_e3",   bus1.sw2,        8'h3C);
        chk("pol_level_e3", bus1.btn1_level, 8'h00);
        chk("pol_flag_e3",  bus1.btn1,       8'h00);

        // Asynchronous reset clears without a clock edge; nothing moves on release.
        bus0.sw1_raw = 8'hFF;
        ticks(2);
        #2;
        mem_reset = 1'b1;
        #1;
        chk("arst_sw1",  bus0.sw1,  8'h00);
        chk("arst_btn1", bus0.btn1, 8'h00);
        chk("arst_ah",   bus1.sw1,  8'h00);
        tick();
        mem_reset = 1'b0;
        bus1.sw1_raw = 8'h00;
        bus1.sw2_raw = 8'h00;
        ticks(8);
        chk("post_sw1",   bus0.sw1,        8'h00);
        chk("post_level", bus0.btn1_level, 8'h08);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/io_debounce.md
Name: io_debounce

Overview:
- Input-conditioning stage directly upstream of the memory block's read-only I/O addresses.
  - sw1 feeds 7FFE.
  - sw2 feeds 7FFD.
  - btn1 feeds 7FFC.
- Synchronises and debounces 24 raw board inputs: two 8-bit DIP banks and one 8-bit push-button bank.
- Presents debounced switch levels.
- Presents sticky button-press flags that software reads at 7FFC and acknowledges by that same read.

Parameters:
- SYNC_STAGES, 2: synchroniser flops per input bit (minimum 2).
- DB_WIDTH, 16: debounce counter width.
- DB_COUNT, 50000: consecutive stable cycles required before a level change is accepted. Range 1 to 2^DB_WIDTH-1.
- ACTIVE_LOW, 1: when 1, all raw inputs are inverted before synchronisation, so pressed/on reads as 1.

Ports:
- mem_clk: in, 1. Single clock for all logic.
- mem_reset: in, 1. Asynchronous, active-high reset.
- sw1_raw: in, 8. Raw DIP bank 1, asynchronous.
- sw2_raw: in, 8. Raw DIP bank 2, asynchronous.
- btn1_raw: in, 8. Raw push buttons, asynchronous.
- btn_clr: in, 1. One-cycle acknowledge pulse, driven by (read && address == 15'h7FFC).
- sw1: out, 8. Debounced DIP bank 1 level.
- sw2: out, 8. Debounced DIP bank 2 level.
- btn1: out, 8. Sticky press flags, one per button.
- btn1_level: out, 8. Debounced button level (not memory-mapped; debug/LED use).

Behaviour:
- Reset (asynchronous, mem_reset=1)
  - Clears all synchroniser flops, debounce counters, stable levels and press flags to 0.
  - Outputs sw1, sw2, btn1, btn1_level = 8'h00 while reset is held and immediately after release.
  - Reset asserted mid-debounce discards the partial count; no output changes on release.
- Polarity
  - ACTIVE_LOW=1 applies x = ~raw before the synchroniser; ACTIVE_LOW=0 passes raw unchanged.
- Synchroniser
  - Per bit, SYNC_STAGES-flop chain. s = last stage output.
- Debounce, independently per bit (24 identical channels)
  - State per bit: stable (1 bit) and cnt (DB_WIDTH bits).
  - If s == stable: cnt <= 0.
  - Else if cnt == DB_COUNT-1: stable <= s, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any return of s to stable before acceptance restarts the count from 0. There is no partial credit.
  - Latency: a clean raw change that meets the setup time of edge 1 appears on the output after edge SYNC_STAGES+DB_COUNT.
  - A pulse on s shorter than DB_COUNT cycles never reaches the output.
  - DB_COUNT=1: stable follows s one cycle after the mismatch, i.e. a pure synchroniser plus one register.
- Output mapping
  - sw1 = stable[7:0], sw2 = stable[15:8], btn1_level = stable[23:16]. Registered outputs, no combinational path from raw inputs.
- Press flags, per button bit i
  - rise_i = stable[16+i] going 0->1 on this edge.
  - flag_i next value = rise_i | (flag_i & ~btn_clr).
  - A press arriving in the same cycle as btn_clr survives: set wins over clear. Other flags are cleared.
  - Release (1->0) never sets or clears a flag.
  - Flags stay set indefinitely until btn_clr.
  - A held button sets its flag only once per press.
  - btn_clr held high for multiple cycles clears every cycle; a new rise during that window still sets its flag.
- The counter never wraps: it resets at acceptance. DB_COUNT-1 must fit in DB_WIDTH. Violating this is a configuration error and is flagged by an elaboration assertion.
- No other state. All logic is on mem_clk posedge.

Test Plan (SYNC_STAGES=2, DB_COUNT=4, ACTIVE_LOW=1 unless stated):
- Reset value
  - Assert mem_reset with sw1_raw=8'h00 (all on).
  - Require all outputs 8'h00 during reset.
  - After release, require sw1=8'hFF after exactly 6 edges and not before.
- Glitch rejection
  - From settled sw2_raw=8'hFF, drive bit 0 low for 3 cycles, then high.
  - Require sw2 stays 8'h00 throughout.
  - Repeat with 4 cycles low: require sw2=8'h01 at edge 6.
- Bounce restart
  - Toggle btn1_raw[2] on alternate cycles for 10 cycles, then hold it low.
  - Require btn1_level[2]=1 exactly 6 edges after the last toggle, and btn1=8'h04.
- Sticky flag and acknowledge
  - Press then release button 5.
  - Require btn1=8'h20 to persist after release, and btn1_level=0.
  - Pulse btn_clr for one cycle: require btn1=8'h00 on the next edge.
- Set-wins collision
  - Hold flag bit 0 set.
  - Align btn_clr with the debounced rise of button 3.
  - Require btn1=8'h08 after that edge.
- Polarity and independence
  - ACTIVE_LOW=0, DB_COUNT=1.
  - Drive sw1_raw=8'hA5 and sw2_raw=8'h3C in the same cycle.
  - Require both outputs to update together after 3 edges, with no cross-bank interference.
